// File: rtl/ex_pipe_mc.sv
// Execute stage: single-cycle ALU with an optional iterative shift-add multiplier.
// Define EX_PIPE_MUL_EN to build the multi-cycle MUL (alu_op 10); otherwise it yields 0.
module ex_pipe_mc #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            valid_ex,
   input  logic [4:0]      rd_ex,
   input  logic [8:0]      ctrl_ex,
   input  logic [XLEN-1:0] r_data1,
   input  logic [XLEN-1:0] r_data2,
   input  logic [XLEN-1:0] extended,
   output logic            stall_ex,
   output logic            valid_mem,
   output logic [3:0]      ctrl_mem,
   output logic [4:0]      rd_mem,
   output logic [XLEN-1:0] alu_result,
   output logic [XLEN-1:0] write_data1
);

   localparam int SHW = $clog2(XLEN);

   logic [3:0]      alu_op;
   logic [XLEN-1:0] op_b;
   logic [SHW-1:0]  shamt;
   logic [XLEN-1:0] alu_out;

   assign alu_op = ctrl_ex[4:1];
   assign op_b   = ctrl_ex[0] ? extended : r_data2;
   assign shamt  = op_b[SHW-1:0];

   always_comb begin
      alu_out = '0;
      case (alu_op)
         4'd0:    alu_out = r_data1 + op_b;
         4'd1:    alu_out = r_data1 - op_b;
         4'd2:    alu_out = r_data1 & op_b;
         4'd3:    alu_out = r_data1 | op_b;
         4'd4:    alu_out = r_data1 << shamt;
         4'd5:    alu_out = {{(XLEN-1){1'b0}}, ($signed(r_data1) < $signed(op_b))};
         4'd6:    alu_out = r_data1 ^ op_b;
         4'd7:    alu_out = r_data1 >> shamt;
         4'd8:    alu_out = $unsigned($signed(r_data1) >>> shamt);
         4'd9:    alu_out = {{(XLEN-1){1'b0}}, (r_data1 < op_b)};
         default: alu_out = '0;
      endcase
   end

   logic            nxt_valid;
   logic [3:0]      nxt_ctrl;
   logic [4:0]      nxt_rd;
   logic [XLEN-1:0] nxt_result;
   logic [XLEN-1:0] nxt_wdata;

`ifdef EX_PIPE_MUL_EN
   typedef enum logic {IDLE, BUSY} state_t;

   state_t          state;
   logic [SHW-1:0]  count;
   logic [XLEN-1:0] mcand;
   logic [XLEN-1:0] mplier;
   logic [XLEN-1:0] acc;
   logic [3:0]      mul_ctrl;
   logic [4:0]      mul_rd;
   logic [XLEN-1:0] mul_wdata;
   logic            mul_start;
   logic [XLEN-1:0] acc_step;

   assign mul_start = (state == IDLE) && valid_ex && (alu_op == 4'd10);
   assign acc_step  = acc + (mplier[0] ? mcand : '0);
   // Stall covers the entry cycle plus every BUSY cycle except the final one.
   assign stall_ex  = reset_n && (mul_start || ((state == BUSY) && (count != '0)));

   always_comb begin
      nxt_valid  = 1'b0;
      nxt_ctrl   = '0;
      nxt_rd     = '0;
      nxt_result = '0;
      nxt_wdata  = '0;
      if (state == BUSY) begin
         if (count == '0) begin
            nxt_valid  = 1'b1;
            nxt_ctrl   = mul_ctrl;
            nxt_rd     = mul_rd;
            nxt_result = acc_step;
            nxt_wdata  = mul_wdata;
         end
      end else if (valid_ex && !mul_start) begin
         nxt_valid  = 1'b1;
         nxt_ctrl   = ctrl_ex[8:5];
         nxt_rd     = rd_ex;
         nxt_result = alu_out;
         nxt_wdata  = r_data2;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         count     <= '0;
         mcand     <= '0;
         mplier    <= '0;
         acc       <= '0;
         mul_ctrl  <= '0;
         mul_rd    <= '0;
         mul_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (mul_start) begin
                  state     <= BUSY;
                  count     <= SHW'(XLEN - 1);
                  mcand     <= r_data1;
                  mplier    <= op_b;
                  acc       <= '0;
                  mul_ctrl  <= ctrl_ex[8:5];
                  mul_rd    <= rd_ex;
                  mul_wdata <= r_data2;
               end
            end
            BUSY: begin
               acc    <= acc_step;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               if (count == '0) begin
                  state <= IDLE;
               end else begin
                  count <= count - SHW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
`else
   assign stall_ex = 1'b0;

   always_comb begin
      nxt_valid  = 1'b0;
      nxt_ctrl   = '0;
      nxt_rd     = '0;
      nxt_result = '0;
      nxt_wdata  = '0;
      if (valid_ex) begin
         nxt_valid  = 1'b1;
         nxt_ctrl   = ctrl_ex[8:5];
         nxt_rd     = rd_ex;
         nxt_result = alu_out;
         nxt_wdata  = r_data2;
      end
   end
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_mem   <= 1'b0;
         ctrl_mem    <= '0;
         rd_mem      <= '0;
         alu_result  <= '0;
         write_data1 <= '0;
      end else begin
         valid_mem   <= nxt_valid;
         ctrl_mem    <= nxt_ctrl;
         rd_mem      <= nxt_rd;
         alu_result  <= nxt_result;
         write_data1 <= nxt_wdata;
      end
   end

endmodule

// File: tb/tb_ex_pipe_mc.sv
// Self-checking bench for ex_pipe_mc (XLEN=64): directed corner cases plus random ops
// checked against an arithmetic reference model. Honours EX_PIPE_MUL_EN like the design.
module tb_ex_pipe_mc;

`ifdef EX_PIPE_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        valid_ex = 1'b0;
   logic [4:0]  rd_ex = '0;
   logic [8:0]  ctrl_ex = '0;
   logic [63:0] r_data1 = '0;
   logic [63:0] r_data2 = '0;
   logic [63:0] extended = '0;
   logic        stall_ex;
   logic        valid_mem;
   logic [3:0]  ctrl_mem;
   logic [4:0]  rd_mem;
   logic [63:0] alu_result;
   logic [63:0] write_data1;

   int checks = 0;
   int errors = 0;

   ex_pipe_mc #(.XLEN(64)) dut (
      .clk(clk), .reset_n(reset_n), .valid_ex(valid_ex), .rd_ex(rd_ex),
      .ctrl_ex(ctrl_ex), .r_data1(r_data1), .r_data2(r_data2), .extended(extended),
      .stall_ex(stall_ex), .valid_mem(valid_mem), .ctrl_mem(ctrl_mem), .rd_mem(rd_mem),
      .alu_result(alu_result), .write_data1(write_data1)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference ALU expressed as plain arithmetic on the operand values.
   function automatic logic [63:0] ref_alu(input logic [3:0] op, input logic [63:0] a,
                                           input logic [63:0] b);
      logic [63:0] pw;
      pw = 64'd1 << (b % 64);
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a * pw;
         4'd5:    return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
         4'd6:    return a ^ b;
         4'd7:    return a / pw;
         4'd8:    return a[63] ? ~((~a) / pw) : a / pw;
         4'd9:    return (a < b) ? 64'd1 : 64'd0;
         4'd10:   return MUL_EN ? a * b : 64'd0;
         default: return 64'd0;
      endcase
   endfunction

   // Called just after a rising edge; returns just after the edge that delivers the result.
   task automatic do_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b2,
                        input logic [63:0] ext, input logic src, input logic [4:0] rd,
                        input logic [3:0] mc, input logic [63:0] exp);
      int stalls;
      int exp_stalls;
      exp_stalls = (MUL_EN && op == 4'd10) ? 64 : 0;
      valid_ex = 1'b1; ctrl_ex = {mc, op, src}; rd_ex = rd;
      r_data1 = a; r_data2 = b2; extended = ext;
      #1;
      stalls = 0;
      while (stall_ex === 1'b1 && stalls < 200) begin
         stalls++;
         @(posedge clk); #1;
         check("bubble_valid", {63'd0, valid_mem}, 64'd0);
         check("bubble_result", alu_result, 64'd0);
         // Inputs are scrambled while busy: the captured operands must be used.
         valid_ex = $urandom_range(0, 1); r_data1 = {$urandom, $urandom};
         r_data2 = {$urandom, $urandom}; extended = {$urandom, $urandom};
         #1;
      end
      valid_ex = 1'b1; r_data1 = a; r_data2 = b2; extended = ext;
      check("stall_cycles", 64'(stalls), 64'(exp_stalls));
      @(posedge clk); #1;
      check("valid_mem", {63'd0, valid_mem}, 64'd1);
      check("alu_result", alu_result, exp);
      check("ctrl_mem", {60'd0, ctrl_mem}, {60'd0, mc});
      check("rd_mem", {59'd0, rd_mem}, {59'd0, rd});
      check("write_data1", write_data1, b2);
      $display("op=%0d a=%h b=%h src=%0d -> result=%h stalls=%0d", op, a, (src ? ext : b2),
               src, alu_result, stalls);
   endtask

   task automatic do_bubble();
      valid_ex = 1'b0; ctrl_ex = 9'($urandom); rd_ex = 5'($urandom);
      r_data1 = {$urandom, $urandom}; r_data2 = {$urandom, $urandom};
      @(posedge clk); #1;
      check("bub_valid", {63'd0, valid_mem}, 64'd0);
      check("bub_ctrl", {60'd0, ctrl_mem}, 64'd0);
      check("bub_rd", {59'd0, rd_mem}, 64'd0);
      check("bub_result", alu_result, 64'd0);
      check("bub_wdata", write_data1, 64'd0);
      $display("bubble -> valid_mem=%0d", valid_mem);
   endtask

   initial begin
      logic [3:0]  op;
      logic [63:0] a, b2, ext, bsel;
      logic        src;

      #3;
      check("rst_valid", {63'd0, valid_mem}, 64'd0);
      check("rst_result", alu_result, 64'd0);
      check("rst_stall", {63'd0, stall_ex}, 64'd0);
      @(negedge clk); reset_n = 1'b1;
      @(posedge clk); #1;

      do_op(4'd0, 64'd5, 64'd99, -64'sd3, 1'b1, 5'd1, 4'h3, 64'd2);
      do_op(4'd8, 64'h8000_0000_0000_0000, 64'd68, 64'd0, 1'b0, 5'd2, 4'h5,
            64'hF800_0000_0000_0000);
      do_op(4'd5, -64'sd1, 64'd1, 64'd0, 1'b0, 5'd3, 4'h1, 64'd1);
      do_op(4'd9, -64'sd1, 64'd1, 64'd0, 1'b0, 5'd4, 4'h2, 64'd0);
      do_op(4'd12, 64'd77, 64'd3, 64'd0, 1'b0, 5'd5, 4'hF, 64'd0);
      do_bubble();

      // MUL then back-to-back ADD
      do_op(4'd10, 64'd7, 64'd11, -64'sd3, 1'b1, 5'd6, 4'hA, MUL_EN ? -64'sd21 : 64'd0);
      do_op(4'd0, 64'd1, 64'd1, 64'd0, 1'b0, 5'd7, 4'h4, 64'd2);

      // Reset asserted mid-operation
      valid_ex = 1'b1; ctrl_ex = {4'h9, 4'd10, 1'b0}; rd_ex = 5'd8;
      r_data1 = 64'd5; r_data2 = 64'd6;
      if (MUL_EN) begin
         repeat (20) @(posedge clk);
      end else begin
         @(posedge clk);
      end
      #1;
      check("pre_rst_stall", {63'd0, stall_ex}, {63'd0, MUL_EN});
      reset_n = 1'b0; #1;
      check("mid_rst_valid", {63'd0, valid_mem}, 64'd0);
      check("mid_rst_ctrl", {60'd0, ctrl_mem}, 64'd0);
      check("mid_rst_rd", {59'd0, rd_mem}, 64'd0);
      check("mid_rst_result", alu_result, 64'd0);
      check("mid_rst_wdata", write_data1, 64'd0);
      check("mid_rst_stall", {63'd0, stall_ex}, 64'd0);
      valid_ex = 1'b0;
      @(negedge clk); reset_n = 1'b1;
      @(posedge clk); #1;
      do_op(4'd0, 64'd40, 64'd2, 64'd0, 1'b0, 5'd9, 4'h6, 64'd42);

      for (int i = 0; i < 40; i++) begin
         op  = 4'($urandom_range(0, 15));
         a   = {$urandom, $urandom};
         b2  = {$urandom, $urandom};
         ext = ($urandom_range(0, 1) != 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 130));
         src = 1'($urandom_range(0, 1));
         bsel = src ? ext : b2;
         do_op(op, a, b2, ext, src, 5'($urandom), 4'($urandom), ref_alu(op, a, bsel));
         if ($urandom_range(0, 4) == 0) do_bubble();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ex_pipe_mc.md
EX_PIPE_MC -- requirements
Module: ex_pipe_mc

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width; legal values 32 and 64.
REQ-002 SHALL have ports: clk  input  1  rising-edge clock.
REQ-003 SHALL have ports: reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports: valid_ex  input  1  instruction present in EX.
REQ-005 SHALL have ports: rd_ex  input  5  destination register.
REQ-006 SHALL have ports: ctrl_ex  input  9  [8:5] memory-stage control, [4:1] alu_op, [0] alu_src (1 = extended).
REQ-007 SHALL have ports: r_data1, r_data2, extended  input  XLEN  operands and immediate.
REQ-008 SHALL have ports: stall_ex  output  1  upstream SHALL hold all EX inputs stable while high.
REQ-009 SHALL have ports: valid_mem  output  1; ctrl_mem  output  4; rd_mem  output  5; alu_result  output  XLEN; write_data1  output  XLEN (registered r_data2).

Function
REQ-010 SHALL select operand B = extended when ctrl_ex[0]=1, else r_data2.
REQ-011 SHALL decode alu_op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLL, 5 SLT (signed), 6 XOR, 7 SRL, 8 SRA, 9 SLTU, 10 MUL; 11-15 give result 0.
REQ-012 SHALL use only the low log2(XLEN) bits of B as the shift amount; SLT/SLTU yield 1 or 0 zero-extended to XLEN.
REQ-013 SHALL, for non-MUL ops with valid_ex=1 and stall_ex=0, register result, ctrl_ex[8:5], rd_ex, r_data2 and valid_mem=1 at the next edge (latency 1).
REQ-014 SHALL, when valid_ex=0, register a bubble: valid_mem=0, ctrl_mem=0, rd_mem=0, alu_result=0, write_data1=0.
REQ-015 SHALL implement FSM states IDLE and BUSY with a down-counter of log2(XLEN) bits.
REQ-016 SHALL, in IDLE with valid_ex=1 and alu_op=10, drive stall_ex=1 combinationally, capture operands at the edge, load counter XLEN-1, enter BUSY, and register a bubble.
REQ-017 SHALL, in BUSY, perform one shift-add step per edge, drive stall_ex=1 while counter!=0 and register a bubble at each such edge.
REQ-018 SHALL, in BUSY with counter=0, drive stall_ex=0, perform the final step, register the low XLEN bits of the product plus ctrl/rd/r_data2 with valid_mem=1, and return to IDLE.
REQ-019 SHALL give MUL total latency XLEN+1 edges from first presentation with stall_ex high for exactly XLEN cycles.
REQ-020 SHALL ignore valid_ex and input changes while BUSY (operands were captured at entry).
REQ-021 SHALL accept a non-MUL or MUL instruction on the edge immediately after leaving BUSY without extra bubble.

Reset
REQ-022 SHALL, on reset_n low at any time including mid-MUL, clear all output registers to 0, force IDLE, clear counter and operand registers, and drive stall_ex=0.
REQ-023 SHALL resume normal operation on the first rising clk edge after reset_n deasserts.

Configuration
REQ-024 SHALL compile the iterative multiplier only when macro EX_PIPE_MUL_EN is defined.
REQ-025 SHALL, without EX_PIPE_MUL_EN, treat alu_op 10 as undefined (result 0, latency 1), omit FSM/counter, and tie stall_ex to 0.

Verification
REQ-026 SHALL cover: XLEN=64, ADD r1=5, extended=-3, alu_src=1 -> next edge alu_result=2, valid_mem=1.
REQ-027 SHALL cover: SRA r1=0x8000_0000_0000_0000, B=68 -> shift 4 -> 0xF800_0000_0000_0000; SLT -1 vs 1 -> 1; SLTU -1 vs 1 -> 0.
REQ-028 SHALL cover: MUL 7 x -3 with EX_PIPE_MUL_EN -> stall_ex high 64 cycles, bubbles meanwhile, then alu_result=-21 (two's complement), valid_mem=1 once.
REQ-029 SHALL cover: reset_n pulsed low at MUL cycle 20 -> outputs 0, stall_ex 0, next ADD completes in 1 cycle.
REQ-030 SHALL cover: MUL followed back-to-back by ADD 1+1 -> ADD result 2 one edge after MUL result; without EX_PIPE_MUL_EN MUL -> result 0, stall_ex never high.
